// File: rtl/smem_ctrl_pkg.sv
// Shared types and constants for the screen-memory fill/scroll engine.
package smem_ctrl_pkg;

    localparam int SMEM_COLS = 40;

    typedef enum logic [1:0] {
        OP_NOP    = 2'd0,
        OP_FILL   = 2'd1,
        OP_SCROLL = 2'd2,
        OP_RSVD   = 2'd3
    } smem_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_SCR_RD = 3'd2,
        ST_SCR_WR = 3'd3,
        ST_DONE   = 3'd4
    } smem_state_t;

endpackage

// File: rtl/smem_wrap_counter.sv
// Loadable address counter with enable that wraps from Nloc-1 back to 0.
module smem_wrap_counter #(
    parameter int Nloc  = 1200,
    parameter int Abits = $clog2(Nloc)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             en,
    input  logic [Abits-1:0] load_val,
    output logic [Abits-1:0] count
);

    localparam logic [Abits-1:0] LAST = Abits'(Nloc - 1);

    logic [Abits-1:0] count_r;

    // Address register: load has priority over increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (en) begin
            count_r <= (count_r == LAST) ? '0 : count_r + Abits'(1);
        end
    end

    assign count = count_r;

endmodule

// File: rtl/smem_fill_ctrl.sv
// Fill/scroll engine sharing the screen-memory CPU port; CPU always wins.
// Optional feature macro: SMEM_SCROLL_EN (scroll-up-one-row command).
module smem_fill_ctrl
    import smem_ctrl_pkg::*;
#(
    parameter int  Nloc  = 1200,
    parameter int  Dbits = 4,
    parameter int  Cols  = SMEM_COLS,
    localparam int Abits = $clog2(Nloc)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [Dbits-1:0] cmd_data,
    input  logic [Abits-1:0] cmd_start,
    input  logic [Abits:0]   cmd_count,
    output logic             busy,
    output logic             done,
    input  logic             cpu_en,
    input  logic             cpu_wr,
    input  logic [Abits-1:0] cpu_addr,
    input  logic [Dbits-1:0] cpu_writedata,
    output logic             smem_wr,
    output logic [Abits-1:0] smem_addr,
    output logic [Dbits-1:0] smem_writedata,
    input  logic [Dbits-1:0] smem_readdata
);

    smem_state_t      state_r, state_s;
    logic [Dbits-1:0] data_r, data_s;
    logic [Abits:0]   rem_r, rem_s;
    logic [Abits-1:0] addr_s, ld_val_s;
    logic             ld_s, inc_s, grant_s;
    logic             eng_wr_s;
    logic [Abits-1:0] eng_addr_s;
    logic [Dbits-1:0] eng_data_s;
`ifdef SMEM_SCROLL_EN
    logic [Dbits-1:0] hold_r, hold_s;
`else
    logic             rdata_unused_s;
    assign rdata_unused_s = ^smem_readdata;
`endif

    function automatic logic [Abits:0] clamp_count(input logic [Abits:0] c);
        return (c > (Abits+1)'(Nloc)) ? (Abits+1)'(Nloc) : c;
    endfunction

    assign grant_s = ~cpu_en;

    smem_wrap_counter #(.Nloc(Nloc), .Abits(Abits)) u_addr_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (ld_s),
        .en       (inc_s),
        .load_val (ld_val_s),
        .count    (addr_s)
    );

    // Next-state and engine-side port drive; engine only advances on granted cycles.
    always_comb begin
        state_s    = state_r;
        data_s     = data_r;
        rem_s      = rem_r;
        ld_s       = 1'b0;
        ld_val_s   = '0;
        inc_s      = 1'b0;
        eng_wr_s   = 1'b0;
        eng_addr_s = cpu_addr;
        eng_data_s = data_r;
`ifdef SMEM_SCROLL_EN
        hold_s     = hold_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (smem_op_t'(cmd_op))
                        OP_FILL: begin
                            data_s   = cmd_data;
                            ld_s     = 1'b1;
                            ld_val_s = cmd_start;
                            rem_s    = clamp_count(cmd_count);
                            if (cmd_count == '0) begin
                                state_s = ST_DONE;
                            end else begin
                                state_s = ST_FILL;
                            end
                        end
`ifdef SMEM_SCROLL_EN
                        OP_SCROLL: begin
                            data_s   = cmd_data;
                            ld_s     = 1'b1;
                            ld_val_s = '0;
                            rem_s    = (Abits+1)'(Nloc - Cols);
                            state_s  = ST_SCR_RD;
                        end
`endif
                        default: state_s = ST_DONE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                eng_wr_s   = 1'b1;
                eng_addr_s = addr_s;
                if (grant_s) begin
                    inc_s = 1'b1;
                    rem_s = rem_r - (Abits+1)'(1);
                    if (rem_r == (Abits+1)'(1)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
`ifdef SMEM_SCROLL_EN
            ST_SCR_RD: begin
                eng_addr_s = addr_s + Abits'(Cols);
                if (grant_s) begin
                    hold_s  = smem_readdata;
                    state_s = ST_SCR_WR;
                end else begin
                    state_s = ST_SCR_RD;
                end
            end
            ST_SCR_WR: begin
                eng_wr_s   = 1'b1;
                eng_addr_s = addr_s;
                eng_data_s = hold_r;
                if (grant_s) begin
                    if (rem_r == (Abits+1)'(1)) begin
                        // Last copy done: blank the vacated bottom row as a plain fill.
                        ld_s     = 1'b1;
                        ld_val_s = Abits'(Nloc - Cols);
                        rem_s    = (Abits+1)'(Cols);
                        state_s  = ST_FILL;
                    end else begin
                        inc_s   = 1'b1;
                        rem_s   = rem_r - (Abits+1)'(1);
                        state_s = ST_SCR_RD;
                    end
                end else begin
                    state_s = ST_SCR_WR;
                end
            end
`endif
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Engine state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            data_r  <= '0;
            rem_r   <= '0;
`ifdef SMEM_SCROLL_EN
            hold_r  <= '0;
`endif
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            rem_r   <= rem_s;
`ifdef SMEM_SCROLL_EN
            hold_r  <= hold_s;
`endif
        end
    end

    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign done      = (state_r == ST_DONE);

    // Port arbitration: CPU first, then a busy engine, else an idle read of cpu_addr.
    always_comb begin
        smem_wr        = 1'b0;
        smem_addr      = cpu_addr;
        smem_writedata = cpu_writedata;
        if (cpu_en) begin
            smem_wr        = cpu_wr;
            smem_addr      = cpu_addr;
            smem_writedata = cpu_writedata;
        end else if (state_r != ST_IDLE) begin
            smem_wr        = eng_wr_s;
            smem_addr      = eng_addr_s;
            smem_writedata = eng_data_s;
        end else begin
            smem_wr        = 1'b0;
            smem_addr      = cpu_addr;
            smem_writedata = cpu_writedata;
        end
    end

endmodule
